// File: rtl/opsum_reducer.sv
// opsum_reducer: merges the PE-array psums with the stored ipsums and streams
// the results to the GLB.
//
// A pass runs in three phases:
//   ACC   - Each accepted PE beat is added lane by lane to the oldest ipsum.
//           The sum is saturated and stored per row and beat.
//   DRAIN - The stored results are packed two beats per 32-bit word and sent
//           row by row under a valid/ready handshake.
//   DONE  - A one-cycle completion pulse, then the block returns to IDLE.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begins a pass when sampled in IDLE
//   row_en           number of active rows; clamped to ROW_NUM
//   ipsum_in         oldest ipsum per row from the ipsum buffer
//   pe_psum_in       PE-array psum per row
//   pe_valid         PE beat handshake in
//   pe_ready         PE beat handshake out
//   ipsum_shift      advances the ipsum buffer on every accepted beat
//   opsum_out        packed result word to the GLB
//   opsum_valid      result word handshake out
//   opsum_ready      result word handshake in
//   busy             high whenever the block is not in IDLE
//   done             high for one cycle at the end of a pass

// One row of result storage, holding DEPTH saturated sums.
module opsum_reducer_lane #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int BW     = 2,
    parameter int JW     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [BW-1:0]         beat,
    input  logic                  active,
    input  logic [DATA_W-1:0]     ipsum,
    input  logic [DATA_W-1:0]     psum,
    input  logic [JW-1:0]         word_sel,
    output logic [2*DATA_W-1:0]   word
);
    logic [DEPTH-1:0][DATA_W-1:0] res;
    logic [DATA_W:0]              sum;
    logic [DATA_W-1:0]            sat;

    // Sign-extend both operands by one bit. If the two top bits of the
    // result differ, the sum overflowed, and the top bit gives the direction.
    always_comb begin
        sum = {ipsum[DATA_W-1], ipsum} + {psum[DATA_W-1], psum};
        if (sum[DATA_W] != sum[DATA_W-1])
            sat = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat = sum[DATA_W-1:0];
    end

    // Inactive rows store zero, so results left over from an earlier pass
    // are overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            res <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < DEPTH; k++)
                if (beat == BW'(k))
                    res[k] <= active ? sat : '0;
        end
    end

    // Even beat in the upper half of the word, odd beat in the lower half.
    always_comb begin
        word = '0;
        for (int k = 0; k < DEPTH/2; k++)
            if (word_sel == JW'(k))
                word = {res[2*k], res[2*k+1]};
    end
endmodule

module opsum_reducer #(
    parameter int ROW_NUM = 32,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [5:0]                  row_en,
    input  logic [ROW_NUM*DATA_W-1:0]   ipsum_in,
    input  logic [ROW_NUM*DATA_W-1:0]   pe_psum_in,
    input  logic                        pe_valid,
    output logic                        pe_ready,
    output logic                        ipsum_shift,
    output logic [2*DATA_W-1:0]         opsum_out,
    output logic                        opsum_valid,
    input  logic                        opsum_ready,
    output logic                        busy,
    output logic                        done
);
    localparam int BW  = $clog2(DEPTH);
    localparam int WPR = DEPTH / 2;
    localparam int JW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int EW  = $clog2(ROW_NUM + 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t                             state, state_n;
    logic [BW-1:0]                      beat;
    logic [RW-1:0]                      drain_row;
    logic [JW-1:0]                      drain_j;
    logic [EW-1:0]                      eff_rows, eff_next;
    logic                               beat_fire, word_fire, last_beat, last_word;
    logic [ROW_NUM-1:0][2*DATA_W-1:0]   lane_word;

    always_comb begin
        if (32'(row_en) > ROW_NUM) eff_next = EW'(ROW_NUM);
        else                       eff_next = EW'(row_en);
    end

    assign beat_fire = pe_valid && (state == ACC);
    assign word_fire = opsum_ready && (state == DRAIN);
    assign last_beat = (beat == BW'(DEPTH-1));
    assign last_word = (32'(drain_row) + 1 == 32'(eff_rows)) && (drain_j == JW'(WPR-1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start) state_n = (eff_next == '0) ? DONE : ACC;
            ACC:   if (beat_fire && last_beat) state_n = DRAIN;
            DRAIN: if (word_fire && last_word) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pe_ready    = (state == ACC);
        ipsum_shift = beat_fire;
        opsum_valid = (state == DRAIN);
        busy        = (state != IDLE);
        done        = (state == DONE);
        opsum_out   = '0;
        if (state == DRAIN)
            for (int r = 0; r < ROW_NUM; r++)
                if (drain_row == RW'(r))
                    opsum_out = lane_word[r];
    end

    // Beat and word counters. eff_rows is captured once at start, so later
    // changes to row_en have no effect on the pass in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat      <= '0;
            drain_row <= '0;
            drain_j   <= '0;
            eff_rows  <= '0;
        end else begin
            if (state == IDLE && start) begin
                beat      <= '0;
                drain_row <= '0;
                drain_j   <= '0;
                eff_rows  <= eff_next;
            end
            if (beat_fire)
                beat <= beat + 1'b1;
            if (word_fire) begin
                if (drain_j == JW'(WPR-1)) begin
                    drain_j   <= '0;
                    drain_row <= drain_row + 1'b1;
                end else begin
                    drain_j <= drain_j + 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < ROW_NUM; r++) begin : g_lane
        opsum_reducer_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .BW     (BW),
            .JW     (JW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (beat_fire),
            .beat     (beat),
            .active   (32'(eff_rows) > r),
            .ipsum    (ipsum_in[r*DATA_W +: DATA_W]),
            .psum     (pe_psum_in[r*DATA_W +: DATA_W]),
            .word_sel (drain_j),
            .word     (lane_word[r])
        );
    end
endmodule

// File: tb/tb_opsum_reducer.sv
// Directed bench for opsum_reducer.
//
// The reference model computes each expected word from the applied beat data
// using the saturating sum and the packing order. A negedge monitor then
// compares every handshaken word against the queue of expected words, and
// checks hold stability, the done pulse and the ipsum_shift pulses.
module tb_opsum_reducer;
    localparam int RN = 32;
    localparam int W  = 16;

    logic              clk = 0;
    logic              reset, start, pe_valid, opsum_ready;
    logic [5:0]        row_en;
    logic [RN*W-1:0]   ipsum_in, pe_psum_in;
    logic              pe_ready, ipsum_shift, opsum_valid, busy, done;
    logic [31:0]       opsum_out;

    opsum_reducer #(.ROW_NUM(RN), .DATA_W(W), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .row_en(row_en),
        .ipsum_in(ipsum_in), .pe_psum_in(pe_psum_in), .pe_valid(pe_valid),
        .pe_ready(pe_ready), .ipsum_shift(ipsum_shift), .opsum_out(opsum_out),
        .opsum_valid(opsum_valid), .opsum_ready(opsum_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, word_cnt = 0, shift_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs = 0;
    logic [31:0] exp_q[$];
    logic [RN*W-1:0] ip_v[4], pe_v[4];
    logic held_v = 0, prev_done = 0;
    logic [31:0] held_w = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = $signed(a) + $signed(b);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [31:0] model_word(input int r, input int j);
        return {sat16(ip_v[2*j][r*W +: W], pe_v[2*j][r*W +: W]),
                sat16(ip_v[2*j+1][r*W +: W], pe_v[2*j+1][r*W +: W])};
    endfunction

    task automatic push_expected(input int eff);
        for (int r = 0; r < eff; r++)
            for (int j = 0; j < 2; j++)
                exp_q.push_back(model_word(r, j));
    endtask

    // Monitor
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            held_v    = 0;
            prev_done = 0;
        end else begin
            if (held_v) check("hold_stable", opsum_out, held_w);
            if (opsum_valid && opsum_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
                else                   check("word", opsum_out, exp_q.pop_front());
                word_cnt++;
                last_hs = cyc;
            end
            held_v = opsum_valid && !opsum_ready;
            held_w = opsum_out;
            if (ipsum_shift) begin
                shift_cnt++;
                check("shift_only_on_valid", pe_valid, 1);
            end
            if (prev_done) check("done_width", done, 0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = done;
        end
    end

    task automatic fill_const(input int base, input int pe_val);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < RN; r++) begin
                ip_v[k][r*W +: W] = 16'(base + k);
                pe_v[k][r*W +: W] = 16'(pe_val);
            end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < RN; r++) begin
                ip_v[k][r*W +: W] = 16'($urandom);
                pe_v[k][r*W +: W] = 16'($urandom);
            end
    endtask

    task automatic send_beats(input int gap, input bit mid_start);
        for (int k = 0; k < 4; k++) begin
            repeat (gap) begin
                pe_valid = 0;
                @(posedge clk); #1;
            end
            if (mid_start && k == 2) start = 1;
            ipsum_in   = ip_v[k];
            pe_psum_in = pe_v[k];
            pe_valid   = 1;
            @(negedge clk);
            check("pe_ready_in_acc", pe_ready, 1);
            @(posedge clk); #1;
            start = 0;
        end
        pe_valid = 0;
    endtask

    task automatic run_pass(input int ren, input int gap, input bit bp, input bit mid_start);
        int eff, w0, s0, d0, t, bp_left;
        eff = (ren > 32) ? 32 : ren;
        w0 = word_cnt; s0 = shift_cnt; d0 = done_cnt;
        push_expected(eff);
        opsum_ready = 1;
        row_en = 6'(ren);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        if (eff == 0) begin
            @(negedge clk);
            check("zero_busy", busy, 1);
            check("zero_done", done, 1);
            check("zero_pe_ready", pe_ready, 0);
            @(posedge clk); #1;
        end else begin
            if (mid_start) row_en = 6'd5;
            send_beats(gap, mid_start);
            @(negedge clk);
            check("first_word_valid", opsum_valid, 1);
            bp_left = 5; t = 0;
            while (done_cnt == d0 && t < 2000) begin
                @(posedge clk); #1;
                if (bp && (word_cnt - w0) == 1 && bp_left > 0) begin
                    opsum_ready = 0;
                    bp_left--;
                end else begin
                    opsum_ready = 1;
                end
                t++;
            end
            check("done_latency", done_cyc, last_hs + 1);
            check("shift_count", shift_cnt - s0, 4);
        end
        check("done_count", done_cnt - d0, 1);
        check("word_count", word_cnt - w0, 2 * eff);
        check("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("idle_after", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int w0, d0, t;
        reset = 1; start = 1; pe_valid = 1; opsum_ready = 1; row_en = 6'd2;
        ipsum_in = '1; pe_psum_in = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pe_ready", pe_ready, 0);
        check("rst_shift", ipsum_shift, 0);
        check("rst_valid", opsum_valid, 0);
        check("rst_out", opsum_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        start = 0; pe_valid = 0; reset = 0;
        repeat (2) @(posedge clk); #1;

        // Basic pass: two rows, ipsum equal to beat+1, pe equal to 10.
        fill_const(1, 10);
        check("model_pin0", model_word(0, 0), 32'h000B000C);
        check("model_pin1", model_word(0, 1), 32'h000D000E);
        check("model_pin2", model_word(1, 0), 32'h000B000C);
        run_pass(2, 0, 0, 0);

        // Saturation in both directions on row 0.
        fill_rand();
        ip_v[0][15:0] = 16'h7FF0; pe_v[0][15:0] = 16'h0100;
        ip_v[1][15:0] = 16'h8010; pe_v[1][15:0] = 16'hFF00;
        ip_v[2][15:0] = 16'h0005; pe_v[2][15:0] = 16'hFFFD;
        ip_v[3][15:0] = 16'h8000; pe_v[3][15:0] = 16'h8000;
        check("model_sat0", model_word(0, 0), 32'h7FFF8000);
        check("model_sat1", model_word(0, 1), 32'h00028000);
        run_pass(1, 0, 0, 0);

        // Backpressure held for five cycles on word 1.
        fill_const(1, 10);
        run_pass(3, 0, 1, 0);

        // Gaps in pe_valid, a start pulse during ACC and a row_en change mid-pass.
        fill_rand();
        run_pass(4, 2, 0, 1);

        // No active rows.
        run_pass(0, 0, 0, 0);

        // row_en above ROW_NUM is clamped to 32 rows, giving 64 words.
        fill_rand();
        run_pass(40, 0, 0, 0);

        // Reset in the middle of DRAIN.
        fill_rand();
        push_expected(2);
        w0 = word_cnt; d0 = done_cnt;
        opsum_ready = 1; row_en = 6'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        send_beats(0, 0);
        t = 0;
        while ((word_cnt - w0) < 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_mid_reach", word_cnt - w0, 2);
        reset = 1; opsum_ready = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_valid", opsum_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_out", opsum_out, 0);
        #1 reset = 0;
        exp_q.delete();
        opsum_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_words", word_cnt - w0, 2);

        fill_rand();
        run_pass(2, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/opsum_reducer.md
OPSUM_REDUCER -- requirements
Module: opsum_reducer

Interface
REQ-001 SHALL have parameter ROW_NUM, default 32, meaning number of PE-array rows and ipsum lanes.
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed psum width per lane.
REQ-003 SHALL have parameter DEPTH, default 4, meaning psum beats per row per pass (even, at least 2).
REQ-004 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, begins one reduce pass when sampled high in IDLE.
REQ-007 SHALL have port row_en, input, 6, number of active rows (0..32).
REQ-008 SHALL have port ipsum_in, input, ROW_NUM*DATA_W, oldest ipsum per row from Ipsum_buffer, lane r at bits [r*16 +: 16].
REQ-009 SHALL have port pe_psum_in, input, ROW_NUM*DATA_W, PE-array psum per row, same lane layout.
REQ-010 SHALL have port pe_valid, input, 1, pe_psum_in beat valid.
REQ-011 SHALL have port pe_ready, output, 1, reducer accepts a PE beat.
REQ-012 SHALL have port ipsum_shift, output, 1, pulses to make Ipsum_buffer advance its FIFOs (drives its ipsum_out_f).
REQ-013 SHALL have port opsum_out, output, 32, packed result word to GLB.
REQ-014 SHALL have port opsum_valid, output, 1, opsum_out valid.
REQ-015 SHALL have port opsum_ready, input, 1, GLB accepts word.
REQ-016 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at pass end.

Function
REQ-018 SHALL implement states IDLE, ACC, DRAIN, DONE.
REQ-019 IDLE->ACC on start, clearing beat counter; start in any other state SHALL be ignored.
REQ-020 On entering ACC, SHALL latch eff_rows = min(row_en,32); if eff_rows==0, SHALL go IDLE->DONE directly with no beats or words.
REQ-021 pe_ready SHALL equal (state==ACC); beat accepted when pe_valid && pe_ready.
REQ-022 ipsum_shift SHALL equal pe_valid && pe_ready (combinational, same cycle as acceptance).
REQ-023 On accepted beat k (0..DEPTH-1), for each row r < eff_rows, SHALL store res[r][k] = sat16(ipsum_in lane r + pe_psum_in lane r); rows >= eff_rows SHALL store 0.
REQ-024 sat16: 17-bit signed sum clamped to [-32768, 32767].
REQ-025 After beat DEPTH-1 accepted, SHALL go ACC->DRAIN next cycle; pe_valid low SHALL stall ACC indefinitely.
REQ-026 In DRAIN, SHALL emit DEPTH/2 words per row, row 0 first; word j of row r = {res[r][2j] in [31:16], res[r][2j+1] in [15:0]}.
REQ-027 opsum_valid SHALL be high throughout DRAIN; opsum_out SHALL hold stable until opsum_valid && opsum_ready.
REQ-028 Word index SHALL advance only on handshake; after handshake of last word (row eff_rows-1, j=DEPTH/2-1) SHALL go DRAIN->DONE.
REQ-029 First word SHALL be valid the cycle after the final beat is accepted; at most one word per cycle.
REQ-030 DONE SHALL assert done for exactly one cycle then go IDLE; start sampled in DONE ignored.
REQ-031 row_en changes after ACC entry SHALL not affect the current pass.

Reset
REQ-032 reset SHALL force IDLE, clear beat/word counters, eff_rows and all res entries to 0.
REQ-033 During and after reset: pe_ready=0, ipsum_shift=0, opsum_valid=0, opsum_out=0, busy=0, done=0.
REQ-034 reset mid-ACC or mid-DRAIN SHALL abort the pass with no further words and no done pulse.

Verification
REQ-035 row_en=2, 4 beats, ipsum lanes=1,2,3,4, pe lanes=10 each beat, opsum_ready=1 -> words 0x000B000C,0x000D000E (row0) then row1 same, done 1 cycle after 4th word.
REQ-036 Saturation: ipsum=0x7FF0, pe=0x0100 -> 0x7FFF; ipsum=0x8010, pe=0xFF00 -> 0x8000.
REQ-037 Backpressure: opsum_ready low 5 cycles on word 1 -> opsum_out constant, no word skipped or duplicated, total words = 2*row_en.
REQ-038 pe_valid gaps between beats -> ipsum_shift pulses exactly 4 times, only on accepted beats; results unchanged.
REQ-039 row_en=0 with start -> busy 1 cycle, done pulse, zero words, pe_ready never high; row_en=40 -> 64 words.
REQ-040 reset asserted after 2nd DRAIN word -> opsum_valid low next cycle, no done; new start runs a full clean pass.
